fp32_dot_accumulator: RTL

//  Downstream stage of the FP8xFP8->FP32 multiplier: sums a stream of FP32 products into one FP32
//  dot-product result. A multi-cycle FSM (align/add/normalise) accepts one term every 4 cycles.
//  The term flagged in_last closes the sum. The result is then held on a valid/ready output until
//  it is taken, and the accumulator restarts at +0.

---
 rtl/fp_pkg.sv | 16 +
 rtl/fp32_lzc.sv | 18 +
 rtl/fp32_dot_accumulator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 field constants and the accumulator state encoding.
package fp_pkg;
    localparam int          FP32_EXP_W   = 8;
    localparam int          FP32_MAN_W   = 23;
    localparam int          FP32_BIAS    = 127;
    localparam logic [31:0] FP32_QNAN    = 32'h7FFFFFFF;
    localparam logic [7:0]  FP32_INF_EXP = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_OUT
    } acc_state_t;
endpackage

// File: rtl/fp32_lzc.sv
// Combinational leading-zero counter over a 25-bit magnitude (MSB first).
module fp32_lzc (
    input  logic [24:0] bits,
    output logic [4:0]  count
);
    logic found;

    always_comb begin
        count = 5'd0;
        found = 1'b0;
        for (int i = 24; i >= 0; i--) begin
            if (!found) begin
                if (bits[i]) found = 1'b1;
                else         count = 5'(count + 5'd1);
            end
        end
    end
endmodule

// File: rtl/fp32_dot_accumulator.sv
// Truncating FP32 accumulator: one term per 4 cycles through align/add/normalise,
// result held on a valid/ready port once the last term has been summed.
module fp32_dot_accumulator
    import fp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);
    acc_state_t       state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] count;
    logic             nan_flag, inf_flag, inf_sign, last_flag;

    logic [31:0] op_p0;
    logic [23:0] big_man_p1, small_man_p1;
    logic [7:0]  exp_p1;
    logic        sign_a_p1, sign_b_p1;
    logic [24:0] sum_p2;
    logic [7:0]  exp_p2;
    logic        sign_p2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : CNT_W'(v + 1'b1);
    endfunction

    function automatic logic [31:0] pack_result(input logic nan, input logic inf,
                                                input logic isign, input logic [31:0] a);
        if (nan)      return FP32_QNAN;
        else if (inf) return {isign, FP32_INF_EXP, 23'd0};
        else          return a;
    endfunction

    // ---- align: unpack operand and accumulator, order by exponent ----
    logic        op_nan, op_inf, op_zero, acc_zero, swap;
    logic [7:0]  a_exp, b_exp, diff;
    logic [23:0] a_man, b_man, small_man;

    always_comb begin
        op_nan   = (op_p0[30:23] == FP32_INF_EXP) && (op_p0[22:0] != 23'd0);
        op_inf   = (op_p0[30:23] == FP32_INF_EXP) && (op_p0[22:0] == 23'd0);
        op_zero  = (op_p0[30:23] == 8'd0) || (op_p0[30:23] == FP32_INF_EXP);
        acc_zero = (acc[30:23] == 8'd0) || (acc[30:23] == FP32_INF_EXP);
        a_exp    = acc_zero ? 8'd0 : acc[30:23];
        a_man    = acc_zero ? 24'd0 : {1'b1, acc[22:0]};
        b_exp    = op_zero ? 8'd0 : op_p0[30:23];
        b_man    = op_zero ? 24'd0 : {1'b1, op_p0[22:0]};
        swap     = b_exp > a_exp;
        diff     = swap ? (b_exp - a_exp) : (a_exp - b_exp);
        small_man = swap ? a_man : b_man;
        if (diff >= 8'd25) small_man = 24'd0;
        else               small_man = small_man >> diff;
    end

    // ---- add: signed-magnitude add/sub, larger-exponent operand is "big" ----
    logic [24:0] add_sum;
    logic        add_sign;

    always_comb begin
        if (sign_a_p1 == sign_b_p1) begin
            add_sum  = {1'b0, big_man_p1} + {1'b0, small_man_p1};
            add_sign = sign_a_p1;
        end else if (big_man_p1 >= small_man_p1) begin
            add_sum  = {1'b0, big_man_p1} - {1'b0, small_man_p1};
            add_sign = sign_a_p1;
        end else begin
            add_sum  = {1'b0, small_man_p1} - {1'b0, big_man_p1};
            add_sign = sign_b_p1;
        end
    end

    // ---- normalise: carry/left-shift, then overflow and underflow handling ----
    logic [4:0]        lzc, shamt;
    logic [24:0]       shifted;
    logic signed [9:0] exp_wide, norm_exp;
    logic [31:0]       norm_word;
    logic              ovf, nxt_nan, nxt_inf, nxt_inf_sign;

    fp32_lzc u_lzc (
        .bits  (sum_p2),
        .count (lzc)
    );

    always_comb begin
        shamt    = (lzc == 5'd0) ? 5'd0 : 5'(lzc - 5'd1);
        shifted  = sum_p2 << shamt;
        exp_wide = signed'({2'b00, exp_p2});
        ovf      = 1'b0;
        if (sum_p2[24]) norm_exp = exp_wide + 10'sd1;
        else            norm_exp = exp_wide - signed'({5'd0, shamt});
        if (sum_p2 == 25'd0) begin
            norm_word = 32'd0;
        end else if (norm_exp >= 10'sd255) begin
            norm_word = {sign_p2, FP32_INF_EXP, 23'd0};
            ovf       = 1'b1;
        end else if (norm_exp <= 10'sd0) begin
            norm_word = 32'd0;
        end else if (sum_p2[24]) begin
            norm_word = {sign_p2, norm_exp[7:0], sum_p2[23:1]};
        end else begin
            norm_word = {sign_p2, norm_exp[7:0], shifted[22:0]};
        end
        nxt_nan      = nan_flag | (ovf & inf_flag & (inf_sign != sign_p2));
        nxt_inf      = inf_flag | ovf;
        nxt_inf_sign = inf_flag ? inf_sign : sign_p2;
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_valid && in_ready) op_p0 <= in_data;
        if (state == S_ALIGN) begin
            big_man_p1   <= swap ? b_man : a_man;
            small_man_p1 <= small_man;
            exp_p1       <= swap ? b_exp : a_exp;
            sign_a_p1    <= swap ? op_p0[31] : acc[31];
            sign_b_p1    <= swap ? acc[31] : op_p0[31];
        end
        if (state == S_ADD) begin
            sum_p2  <= add_sum;
            sign_p2 <= add_sign;
            exp_p2  <= exp_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= 32'd0;
            count     <= '0;
            nan_flag  <= 1'b0;
            inf_flag  <= 1'b0;
            inf_sign  <= 1'b0;
            last_flag <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        last_flag <= in_last;
                        count     <= sat_inc(count);
                        in_ready  <= 1'b0;
                        state     <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (op_nan) begin
                        nan_flag <= 1'b1;
                    end else if (op_inf) begin
                        if (inf_flag && (inf_sign != op_p0[31])) nan_flag <= 1'b1;
                        else begin
                            inf_flag <= 1'b1;
                            inf_sign <= op_p0[31];
                        end
                    end
                    state <= S_ADD;
                end
                S_ADD: state <= S_NORM;
                S_NORM: begin
                    acc      <= norm_word;
                    nan_flag <= nxt_nan;
                    inf_flag <= nxt_inf;
                    inf_sign <= nxt_inf_sign;
                    if (last_flag) begin
                        out_valid <= 1'b1;
                        out_data  <= pack_result(nxt_nan, nxt_inf, nxt_inf_sign, norm_word);
                        out_count <= count;
                        state     <= S_OUT;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= 32'd0;
                        count     <= '0;
                        nan_flag  <= 1'b0;
                        inf_flag  <= 1'b0;
                        inf_sign  <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
